// File: rtl/sme_ks_sched_if.sv
// Port bundle for the shared masked-adder scheduler: two requesters, response, randomness and adder sides.
// The slave modport is the scheduler view; the master modport is the surrounding unit's view.
interface sme_ks_sched_if #(
  parameter int D = 3,
  parameter int N = 32
) ();
  logic           a_req;
  logic           a_sub;
  logic [N*D-1:0] a_mxor;
  logic [N*D-1:0] a_mand;
  logic           a_gnt;

  logic           b_req;
  logic           b_sub;
  logic [N*D-1:0] b_mxor;
  logic [N*D-1:0] b_mand;
  logic           b_gnt;

  logic           rsp_vld;
  logic           rsp_id;
  logic [N*D-1:0] rsp_rd;

  logic           rng_vld;
  logic           rng_rdy;

  logic           add_resetn;
  logic           add_en;
  logic           add_sub;
  logic [N*D-1:0] add_mxor;
  logic [N*D-1:0] add_mand;
  logic           add_rdy;
  logic [N*D-1:0] add_rd;

  logic           busy;

  modport slave (
    input  a_req, a_sub, a_mxor, a_mand,
    output a_gnt,
    input  b_req, b_sub, b_mxor, b_mand,
    output b_gnt,
    output rsp_vld, rsp_id, rsp_rd,
    input  rng_vld,
    output rng_rdy,
    output add_resetn, add_en, add_sub, add_mxor, add_mand,
    input  add_rdy, add_rd,
    output busy
  );

  modport master (
    output a_req, a_sub, a_mxor, a_mand,
    input  a_gnt,
    output b_req, b_sub, b_mxor, b_mand,
    input  b_gnt,
    input  rsp_vld, rsp_id, rsp_rd,
    output rng_vld,
    input  rng_rdy,
    input  add_resetn, add_en, add_sub, add_mxor, add_mand,
    output add_rdy, add_rd,
    input  busy
  );
endinterface

// File: rtl/sme_ks_sched.sv
// Round-robin two-port sequencer for the masked Kogge-Stone adder; grant->rsp_vld is 7 cycles with steady randomness.
// Requesters hold until gnt (none while RUN); missing randomness stalls the adder one cycle per gap.
module sme_ks_sched #(
  parameter int D = 3,
  parameter int N = 32,
  parameter int G = D + D*(D-1)/2
) (
  input logic           g_clk,
  input logic           g_reset,
  sme_ks_sched_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic           ptr_q;      // 0: A wins the next contest, 1: B wins
  logic           owner_q;
  logic           sub_q;
  logic [N*D-1:0] mxor_q;
  logic [N*D-1:0] mand_q;
  logic           rsp_vld_q;
  logic           rsp_id_q;
  logic [N*D-1:0] rsp_rd_q;
  logic           a_gnt;
  logic           b_gnt;
  logic           done;

  always_comb begin
    state_d = state_q;
    a_gnt   = 1'b0;
    b_gnt   = 1'b0;
    case (state_q)
      IDLE: begin
        a_gnt = bus.a_req & (~bus.b_req | ~ptr_q);
        b_gnt = bus.b_req & (~bus.a_req |  ptr_q);
        if (a_gnt | b_gnt) state_d = RUN;
      end
      RUN: begin
        if (bus.add_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign done = (state_q == RUN) & bus.add_rdy;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      owner_q   <= 1'b0;
      sub_q     <= 1'b0;
      mxor_q    <= '0;
      mand_q    <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= 1'b0;
      rsp_rd_q  <= '0;
    end else begin
      state_q   <= state_d;
      rsp_vld_q <= done;
      // Shares are copied verbatim; no share ever meets another here.
      if (a_gnt) begin
        mxor_q  <= bus.a_mxor;
        mand_q  <= bus.a_mand;
        sub_q   <= bus.a_sub;
        owner_q <= 1'b0;
        ptr_q   <= 1'b1;
      end else if (b_gnt) begin
        mxor_q  <= bus.b_mxor;
        mand_q  <= bus.b_mand;
        sub_q   <= bus.b_sub;
        owner_q <= 1'b1;
        ptr_q   <= 1'b0;
      end
      if (done) begin
        rsp_rd_q <= bus.add_rd;
        rsp_id_q <= owner_q;
      end
    end
  end

  assign bus.a_gnt      = a_gnt;
  assign bus.b_gnt      = b_gnt;
  assign bus.add_resetn = ~g_reset;
  assign bus.add_en     = (state_q == RUN) & bus.rng_vld & ~bus.add_rdy;
  assign bus.rng_rdy    = bus.add_en;
  assign bus.add_sub    = sub_q;
  assign bus.add_mxor   = mxor_q;
  assign bus.add_mand   = mand_q;
  assign bus.rsp_vld    = rsp_vld_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_rd     = rsp_rd_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sme_ks_sched.sv
// Directed bench for sme_ks_sched with a behavioural 5-step masked adder standing in for sme_ks_adder.
module tb_sme_ks_sched;
  localparam int D = 3;
  localparam int N = 32;
  localparam int W = N*D;

  logic g_clk;
  logic g_reset;
  int   n_chk;
  int   n_fail;

  sme_ks_sched_if #(.D(D), .N(N)) bus ();

  sme_ks_sched #(.D(D), .N(N)) dut (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .bus     (bus.slave)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  function automatic logic [31:0] unmask(input logic [W-1:0] v);
    return v[31:0] ^ v[63:32] ^ v[95:64];
  endfunction

  function automatic logic [W-1:0] mask(input logic [31:0] v);
    logic [31:0] r0, r1;
    r0 = $urandom;
    r1 = $urandom;
    return {v ^ r0 ^ r1, r1, r0};
  endfunction

  // Adder stand-in: ready after five enabled cycles, result re-masked with fixed shares.
  logic [2:0]  mcnt;
  logic [31:0] mres;
  assign bus.add_rdy = (mcnt == 3'd5);
  always_comb begin
    mres = bus.add_sub ? unmask(bus.add_mxor) - unmask(bus.add_mand)
                       : unmask(bus.add_mxor) + unmask(bus.add_mand);
    bus.add_rd = {mres ^ 32'hA5A5_0F0F ^ 32'h1234_5678, 32'h1234_5678, 32'hA5A5_0F0F};
  end
  always_ff @(posedge g_clk) begin
    if (!bus.add_resetn)  mcnt <= 3'd0;
    else if (bus.add_rdy) mcnt <= 3'd0;
    else if (bus.add_en)  mcnt <= mcnt + 3'd1;
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  // One complete operation on a port, optionally contested by the other port in the grant cycle.
  task automatic op(input bit port, input bit sub, input logic [31:0] x, input logic [31:0] y,
                    input logic [31:0] res, input bit contest);
    logic [W-1:0] mx, my, rd_cap;
    mx = mask(x);
    my = mask(y);
    rd_cap = '0;
    tick();
    if (!port) begin
      bus.a_req = 1'b1; bus.a_sub = sub; bus.a_mxor = mx; bus.a_mand = my; bus.b_req = contest;
    end else begin
      bus.b_req = 1'b1; bus.b_sub = sub; bus.b_mxor = mx; bus.b_mand = my; bus.a_req = contest;
    end
    #1;
    chk("gnt_own",   W'(port ? bus.b_gnt : bus.a_gnt), W'(1));
    chk("gnt_other", W'(port ? bus.a_gnt : bus.b_gnt), W'(0));
    chk("en_idle",   W'(bus.add_en), W'(0));
    for (int k = 1; k <= 7; k++) begin
      tick();
      bus.a_req = 1'b0;
      bus.b_req = 1'b0;
      #1;
      if (k <= 5) begin
        chk("en_run",  W'(bus.add_en), W'(1));
        chk("busy",    W'(bus.busy), W'(1));
      end
      if (k <= 6) begin
        chk("op_sub",  W'(bus.add_sub), W'(sub));
        chk("op_mxor", bus.add_mxor, mx);
        chk("op_mand", bus.add_mand, my);
      end
      if (k == 6) begin
        chk("en_rdy",  W'(bus.add_en), W'(0));
        chk("rng_rdy", W'(bus.rng_rdy), W'(0));
        chk("vld_early", W'(bus.rsp_vld), W'(0));
        rd_cap = bus.add_rd;
      end
      if (k == 7) begin
        chk("rsp_vld", W'(bus.rsp_vld), W'(1));
        chk("rsp_id",  W'(bus.rsp_id), W'(port));
        chk("rsp_rd",  bus.rsp_rd, rd_cap);
        chk("rsp_val", W'(unmask(bus.rsp_rd)), W'(res));
        chk("busy_end", W'(bus.busy), W'(0));
      end
    end
  endtask

  initial begin
    logic [W-1:0] mx, my;
    n_chk = 0;
    n_fail = 0;
    g_reset = 1'b1;
    bus.a_req = 1'b0; bus.a_sub = 1'b0; bus.a_mxor = '0; bus.a_mand = '0;
    bus.b_req = 1'b0; bus.b_sub = 1'b0; bus.b_mxor = '0; bus.b_mand = '0;
    bus.rng_vld = 1'b1;

    tick();
    tick();
    chk("rst_resetn", W'(bus.add_resetn), W'(0));
    chk("rst_busy",   W'(bus.busy), W'(0));
    chk("rst_vld",    W'(bus.rsp_vld), W'(0));
    chk("rst_id",     W'(bus.rsp_id), W'(0));
    chk("rst_rd",     bus.rsp_rd, W'(0));
    chk("rst_mxor",   bus.add_mxor, W'(0));
    tick();
    g_reset = 1'b0;
    #1;
    chk("resetn_rel", W'(bus.add_resetn), W'(1));

    // Plain add on A, then subtract with wrap-around on B.
    op(1'b0, 1'b0, 32'd5, 32'd7, 32'd12, 1'b0);
    op(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0);

    // Both ports requesting continuously: A,B,A,B at exactly 7-cycle spacing.
    tick();
    bus.a_req = 1'b1; bus.a_sub = 1'b0; bus.a_mxor = mask(32'd1); bus.a_mand = mask(32'd2);
    bus.b_req = 1'b1; bus.b_sub = 1'b1; bus.b_mxor = mask(32'd9); bus.b_mand = mask(32'd4);
    #1;
    chk("rr_a0", W'(bus.a_gnt), W'(1));
    chk("rr_b0", W'(bus.b_gnt), W'(0));
    for (int k = 1; k <= 28; k++) begin
      tick();
      if (k == 22) begin
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
      end
      #1;
      chk("rr_a", W'(bus.a_gnt), W'((k % 7 == 0) && (k <= 21) && ((k / 7) % 2 == 0)));
      chk("rr_b", W'(bus.b_gnt), W'((k % 7 == 0) && (k <= 21) && ((k / 7) % 2 == 1)));
      if (k % 7 == 0) begin
        chk("rr_vld", W'(bus.rsp_vld), W'(1));
        chk("rr_id",  W'(bus.rsp_id), W'(((k / 7) - 1) % 2));
      end
    end

    // Randomness gap of three cycles stretches the operation to 10 cycles.
    tick();
    bus.a_req = 1'b1; bus.a_sub = 1'b0;
    bus.a_mxor = mask(32'h8000_0000); bus.a_mand = mask(32'h8000_0000);
    #1;
    chk("st_gnt", W'(bus.a_gnt), W'(1));
    for (int k = 1; k <= 10; k++) begin
      tick();
      bus.a_req = 1'b0;
      bus.rng_vld = !(k >= 2 && k <= 4);
      #1;
      chk("st_en",  W'(bus.add_en), W'((k <= 8) && !(k >= 2 && k <= 4)));
      chk("st_rng", W'(bus.rng_rdy), W'((k <= 8) && !(k >= 2 && k <= 4)));
      if (k == 9)  chk("st_vld9", W'(bus.rsp_vld), W'(0));
      if (k == 10) begin
        chk("st_vld", W'(bus.rsp_vld), W'(1));
        chk("st_val", W'(unmask(bus.rsp_rd)), W'(0));
      end
    end
    bus.rng_vld = 1'b1;

    // Reset three cycles into an operation: it vanishes and the pointer returns to A.
    tick();
    bus.a_req = 1'b1; bus.a_sub = 1'b0; bus.a_mxor = mask(32'd9); bus.a_mand = mask(32'd9);
    #1;
    chk("rs_gnt", W'(bus.a_gnt), W'(1));
    for (int k = 1; k <= 10; k++) begin
      tick();
      bus.a_req = 1'b0;
      g_reset = (k == 3);
      #1;
      if (k == 3) chk("rs_resetn", W'(bus.add_resetn), W'(0));
      if (k == 4) chk("rs_busy",   W'(bus.busy), W'(0));
      if (k >= 4) chk("rs_novld",  W'(bus.rsp_vld), W'(0));
    end
    op(1'b0, 1'b0, 32'd2, 32'd2, 32'd4, 1'b1);

    // A request arriving during RUN waits and is granted in the response cycle.
    tick();
    bus.b_req = 1'b1; bus.b_sub = 1'b1; bus.b_mxor = mask(32'h10); bus.b_mand = mask(32'h3);
    #1;
    chk("wr_bgnt", W'(bus.b_gnt), W'(1));
    mx = mask(32'd100);
    my = mask(32'd23);
    for (int k = 1; k <= 14; k++) begin
      tick();
      bus.b_req = 1'b0;
      bus.a_req = (k >= 2 && k <= 7);
      bus.a_sub = 1'b0; bus.a_mxor = mx; bus.a_mand = my;
      #1;
      chk("wr_agnt", W'(bus.a_gnt), W'(k == 7));
      if (k == 7) begin
        chk("wr_vld1", W'(bus.rsp_vld), W'(1));
        chk("wr_id1",  W'(bus.rsp_id), W'(1));
        chk("wr_val1", W'(unmask(bus.rsp_rd)), W'(32'hD));
      end
      if (k == 14) begin
        chk("wr_vld2", W'(bus.rsp_vld), W'(1));
        chk("wr_id2",  W'(bus.rsp_id), W'(0));
        chk("wr_val2", W'(unmask(bus.rsp_rd)), W'(32'd123));
      end
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
